fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end between the program ROM (synchronous Quartus ROM, 16-bit address, 16-bit word) and the core's execute state machine.
- Generates ROM addresses and tracks in-flight reads across the fixed ROM latency.
- Buffers returned words, with their PCs, in a small prefetch FIFO and hands them to the core over a valid/ready handshake.
- Accepts a redirect (jump) from the core, which flushes all buffered and in-flight words.

Parameters:
- ROM_LATENCY, 1, clock edges from the edge that samples address_rom to the edge where q_rom holds that word (legal 1..2).
- FIFO_DEPTH, 4, prefetch FIFO entries (power of two, 2..8).
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- address_rom  out  16  ROM address, equals fetch_pc
- q_rom  in  16  ROM read data
- fetch_en  in  1  1 = issue fetches; 0 = stop issuing (in-flight reads still complete)
- instr_valid  out  1  FIFO head is valid
- instr_ready  in  1  core accepts the head this cycle
- instr_data  out  16  head instruction word
- instr_pc  out  16  address the head word was fetched from
- redirect_valid  in  1  one-cycle jump request
- redirect_pc  in  16  jump target
- busy  out  1  any in-flight read or FIFO entry present

Behaviour:
- Reset (async assert, sync release): state=INIT, fetch_pc=RESET_PC, in-flight pipe cleared, FIFO empty. Outputs: instr_valid=0, instr_data=0, instr_pc=0, busy=0, address_rom=RESET_PC.
- States: INIT, RUN, PAUSE. Reset mid-operation discards everything immediately.
  - INIT -> RUN unconditionally on the first edge.
  - RUN -> PAUSE when fetch_en=0; PAUSE -> RUN when fetch_en=1.
- Issue at an edge when all hold: state=RUN, fetch_en=1, redirect_valid=0, and (fifo_count + inflight_count) < FIFO_DEPTH.
  - On issue: pipe stage0 valid<=1 with tag fetch_pc; fetch_pc<=fetch_pc+1.
  - fetch_pc wraps 16'hFFFF -> 16'h0000.
- In-flight pipe is ROM_LATENCY stages long and shifts every edge. When the last stage is valid, {q_rom, tag} is pushed into the FIFO on that edge.
  - The credit rule guarantees the FIFO never overflows. An overflow is a design error; it is checked by an assertion.
- Pop: instr_valid && instr_ready at the edge. instr_* are FIFO head outputs and are stable while valid=1 and ready=0.
- Push and pop in the same edge: count unchanged. A push into an empty FIFO becomes visible the cycle after the push edge (no bypass).
- Redirect has priority over issue, push and pop in the same edge:
  - FIFO emptied, all pipe valid bits cleared (late ROM data is dropped), fetch_pc<=redirect_pc.
  - No issue occurs on the redirect edge.
  - A redirect while in PAUSE updates fetch_pc but keeps the state PAUSE.
- Latency: with ROM_LATENCY=1, FIFO_DEPTH=4 and fetch_en=1, instr_valid first rises after the 3rd rising edge following reset release. Sustained throughput is 1 word/cycle while instr_ready=1.
- busy = (fifo_count != 0) || any pipe stage valid.

Optional Feature:
- FETCH_PERF_EN defined: adds outputs perf_fetched (16-bit, counts words pushed into the FIFO) and perf_flushed (16-bit, counts words discarded by redirect, FIFO plus in-flight). Both reset to 0 and saturate at 16'hFFFF.
- Not defined: ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - the fetch_state_t enum (INIT, RUN, PAUSE);
  - the fetch_entry_t struct {data[15:0], pc[15:0]};
  - the opcode constants NOP=16'h18 and JMP=16'h06, shared with the core and bench.
- Sub-module: fetch_fifo (parameterised depth, fetch_entry_t payload, push/pop/flush, count output).

Test Plan:
- Reset release, ROM[i]=i+16'h100, instr_ready=1 -> instr_valid after the 3rd edge; pairs (pc 0, 0x100), (1, 0x101), (2, 0x102) on consecutive cycles.
- instr_ready=0 for 10 cycles -> exactly 4 entries buffered, address_rom stops at 4 (holds, no issue), busy=1; release -> pcs 0..3 then 4 with no gap.
- Redirect to 16'h0040 while 3 entries are buffered and 1 is in flight -> instr_valid=0 the next cycle; next delivered pc=0x40, data=ROM[0x40]; stale words never appear; perf_flushed=4 if FETCH_PERF_EN.
- Redirect coinciding with pop and push on the same edge -> the pop is not counted as a delivery; FIFO ends empty; fetch_pc=redirect_pc.
- Redirect to 16'hFFFE, ready=1 -> pcs FFFE, FFFF, 0000, 0001 in order.
- ROM_LATENCY=2 build: steady stream at 1 word/cycle; toggling fetch_en=0 for 5 cycles -> in-flight words still delivered and no new addresses issued; reset_n pulse mid-stream -> instr_valid=0 immediately, then restart from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, opcode constants and helpers for the instruction-fetch front end.
package fetch_pkg;
    typedef enum logic [1:0] {INIT, RUN, PAUSE} fetch_state_t;
    typedef struct packed {
        logic [15:0] data;
        logic [15:0] pc;
    } fetch_entry_t;
    localparam logic [15:0] NOP = 16'h0018;
    localparam logic [15:0] JMP = 16'h0006;
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch FIFO of {data, pc} entries with push/pop/flush; flush wins over everything.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);
    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;
    always_comb begin
        do_pop = pop && count_q != '0;
        mem_d = mem_q;
        if (push && !flush) mem_d[wr_q] = push_entry;
        wr_d = flush ? '0 : wr_q + AW'(push);
        rd_d = flush ? '0 : rd_q + AW'(do_pop);
        count_d = flush ? '0 : count_q + CW'(push) - CW'(do_pop);
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q   <= '{default: '0};
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end
    assign head  = mem_q[rd_q];
    assign count = count_q;
    // The fetch credit rule must keep a push from ever landing on a full FIFO.
    assert property (@(posedge clock) disable iff (!reset_n)
        !(push && !flush && !do_pop && count_q == CW'(DEPTH)));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: ROM address generation, in-flight tracking and prefetch buffering for the core.
// Define FETCH_PERF_EN to add the perf_fetched / perf_flushed saturating counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          ROM_LATENCY = 1,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] RESET_PC    = 16'h0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [15:0] address_rom,
    input  logic [15:0] q_rom,
    input  logic        fetch_en,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr_data,
    output logic [15:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        busy
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_flushed
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    fetch_state_t           state_q, state_d;
    logic [15:0]            fetch_pc_q, fetch_pc_d;
    logic [ROM_LATENCY-1:0] pipe_v_q, pipe_v_d;
    logic [15:0]            pipe_tag_q [ROM_LATENCY];
    logic [15:0]            pipe_tag_d [ROM_LATENCY];
    logic [CW-1:0]          fifo_count;
    fetch_entry_t           head, push_entry;
    logic [4:0]             used;
    logic                   issue, push, pop;
    // Credits count buffered plus in-flight words so a late ROM return always has a slot.
    always_comb begin
        used = 5'(fifo_count);
        for (int i = 0; i < ROM_LATENCY; i++) used = used + 5'(pipe_v_q[i]);
        issue = state_q == RUN && fetch_en && !redirect_valid && used < 5'(FIFO_DEPTH);
        push = pipe_v_q[ROM_LATENCY-1] && !redirect_valid;
        pop = instr_valid && instr_ready && !redirect_valid;
        push_entry.data = q_rom;
        push_entry.pc = pipe_tag_q[ROM_LATENCY-1];
        state_d = (state_q == INIT || fetch_en) ? RUN : PAUSE;
        fetch_pc_d = redirect_valid ? redirect_pc : fetch_pc_q + 16'(issue);
        pipe_v_d = '0;
        pipe_tag_d = pipe_tag_q;
        pipe_v_d[0] = issue;
        pipe_tag_d[0] = fetch_pc_q;
        for (int i = 1; i < ROM_LATENCY; i++) begin
            pipe_v_d[i] = pipe_v_q[i-1];
            pipe_tag_d[i] = pipe_tag_q[i-1];
        end
        if (redirect_valid) pipe_v_d = '0;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= INIT;
            fetch_pc_q <= RESET_PC;
            pipe_v_q   <= '0;
            pipe_tag_q <= '{default: '0};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pipe_v_q   <= pipe_v_d;
            pipe_tag_q <= pipe_tag_d;
        end
    end
    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .count      (fifo_count)
    );
    assign address_rom = fetch_pc_q;
    assign instr_valid = fifo_count != '0;
    assign instr_data  = instr_valid ? head.data : '0;
    assign instr_pc    = instr_valid ? head.pc : '0;
    assign busy        = instr_valid || |pipe_v_q;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched_q, perf_fetched_d, perf_flushed_q, perf_flushed_d;
    always_comb begin
        perf_fetched_d = sat_add(perf_fetched_q, 16'(push));
        perf_flushed_d = redirect_valid ? sat_add(perf_flushed_q, 16'(used)) : perf_flushed_q;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end
    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table on a ROM_LATENCY=1 instance plus hand sequences on a ROM_LATENCY=2 instance.
module tb_fetch_unit;
    typedef struct {
        bit          rst, en, rdy, rv;
        logic [15:0] rpc;
        bit          ev;
        logic [15:0] epc, eaddr;
        bit          eb;
        int          pfe, pfl;
    } vec_t;

    logic        clock = 0;
    logic        reset_n = 1;
    logic        fetch_en = 0, instr_ready = 0, redirect_valid = 0;
    logic [15:0] redirect_pc = '0;
    logic [15:0] addr1, q1, data1, pc1, addr2, q2a, q2, data2, pc2;
    logic        valid1, busy1, valid2, busy2;
`ifdef FETCH_PERF_EN
    logic [15:0] pfe1, pfl1, pfe2, pfl2;
`endif
    int passed = 0, total = 0;
    vec_t tq[$];

    always #5 clock = ~clock;
    always @(posedge clock) q1 <= addr1 + 16'h0100;
    always @(posedge clock) begin
        q2a <= addr2 + 16'h0100;
        q2  <= q2a;
    end

    fetch_unit #(.ROM_LATENCY(1), .FIFO_DEPTH(4), .RESET_PC(16'h0000)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .address_rom(addr1), .q_rom(q1), .fetch_en(fetch_en),
        .instr_valid(valid1), .instr_ready(instr_ready), .instr_data(data1), .instr_pc(pc1),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy1)
`ifdef FETCH_PERF_EN
        , .perf_fetched(pfe1), .perf_flushed(pfl1)
`endif
    );
    fetch_unit #(.ROM_LATENCY(2), .FIFO_DEPTH(4), .RESET_PC(16'h0000)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .address_rom(addr2), .q_rom(q2), .fetch_en(fetch_en),
        .instr_valid(valid2), .instr_ready(instr_ready), .instr_data(data2), .instr_pc(pc2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy2)
`ifdef FETCH_PERF_EN
        , .perf_fetched(pfe2), .perf_flushed(pfl2)
`endif
    );

    function automatic vec_t mk(bit rst, bit en, bit rdy, bit rv, logic [15:0] rpc, bit ev,
                                logic [15:0] epc, logic [15:0] eaddr, bit eb, int pfe = -1, int pfl = -1);
        vec_t v;
        v.rst = rst; v.en = en; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.eb = eb; v.pfe = pfe; v.pfl = pfl;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t v;
        #2;
        // reset release, streaming with ready=1
        tq.push_back(mk(1,0,0,0,0, 0,0,16'h0000,0));
        tq.push_back(mk(0,1,1,0,0, 0,0,16'h0000,0));
        tq.push_back(mk(0,1,1,0,0, 0,0,16'h0001,1));
        tq.push_back(mk(0,1,1,0,0, 1,16'h0000,16'h0002,1));
        tq.push_back(mk(0,1,1,0,0, 1,16'h0001,16'h0003,1));
        tq.push_back(mk(0,1,1,0,0, 1,16'h0002,16'h0004,1));
        // ready=0 for 10 edges fills exactly four entries, then drain
        tq.push_back(mk(1,0,0,0,0, 0,0,16'h0000,0));
        tq.push_back(mk(0,1,0,0,0, 0,0,16'h0000,0));
        tq.push_back(mk(0,1,0,0,0, 0,0,16'h0001,1));
        tq.push_back(mk(0,1,0,0,0, 1,16'h0000,16'h0002,1));
        tq.push_back(mk(0,1,0,0,0, 1,16'h0000,16'h0003,1));
        for (int k = 0; k < 6; k++) tq.push_back(mk(0,1,0,0,0, 1,16'h0000,16'h0004,1));
        tq.push_back(mk(0,1,1,0,0, 1,16'h0001,16'h0004,1));
        tq.push_back(mk(0,1,1,0,0, 1,16'h0002,16'h0005,1));
        tq.push_back(mk(0,1,1,0,0, 1,16'h0003,16'h0006,1));
        tq.push_back(mk(0,1,1,0,0, 1,16'h0004,16'h0007,1));
        // redirect with 3 buffered + 1 in flight
        tq.push_back(mk(1,0,0,0,0, 0,0,16'h0000,0));
        tq.push_back(mk(0,1,0,0,0, 0,0,16'h0000,0));
        tq.push_back(mk(0,1,0,0,0, 0,0,16'h0001,1));
        tq.push_back(mk(0,1,0,0,0, 1,16'h0000,16'h0002,1));
        tq.push_back(mk(0,1,0,0,0, 1,16'h0000,16'h0003,1));
        tq.push_back(mk(0,1,0,0,0, 1,16'h0000,16'h0004,1));
        tq.push_back(mk(0,1,0,1,16'h0040, 0,0,16'h0040,0, 3,4));
        tq.push_back(mk(0,1,1,0,0, 0,0,16'h0041,1));
        tq.push_back(mk(0,1,1,0,0, 1,16'h0040,16'h0042,1));
        tq.push_back(mk(0,1,1,0,0, 1,16'h0041,16'h0043,1));
        // redirect on an edge that would also push and pop
        tq.push_back(mk(0,1,1,1,16'h0080, 0,0,16'h0080,0, 5,6));
        tq.push_back(mk(0,1,1,0,0, 0,0,16'h0081,1));
        tq.push_back(mk(0,1,1,0,0, 1,16'h0080,16'h0082,1));
        // pc wrap
        tq.push_back(mk(0,1,1,1,16'hFFFE, 0,0,16'hFFFE,0));
        tq.push_back(mk(0,1,1,0,0, 0,0,16'hFFFF,1));
        tq.push_back(mk(0,1,1,0,0, 1,16'hFFFE,16'h0000,1));
        tq.push_back(mk(0,1,1,0,0, 1,16'hFFFF,16'h0001,1));
        tq.push_back(mk(0,1,1,0,0, 1,16'h0000,16'h0002,1));
        tq.push_back(mk(0,1,1,0,0, 1,16'h0001,16'h0003,1));
        // pause, redirect while paused, resume
        tq.push_back(mk(0,0,1,0,0, 1,16'h0002,16'h0003,1));
        tq.push_back(mk(0,0,1,0,0, 0,0,16'h0003,0));
        tq.push_back(mk(0,0,1,1,16'h0200, 0,0,16'h0200,0));
        tq.push_back(mk(0,0,1,0,0, 0,0,16'h0200,0));
        tq.push_back(mk(0,1,1,0,0, 0,0,16'h0200,0));
        tq.push_back(mk(0,1,1,0,0, 0,0,16'h0201,1));
        tq.push_back(mk(0,1,1,0,0, 1,16'h0200,16'h0202,1));

        foreach (tq[i]) begin
            v = tq[i];
            fetch_en = v.en; instr_ready = v.rdy; redirect_valid = v.rv; redirect_pc = v.rpc;
            if (v.rst) begin
                reset_n = 0;
                #1;
            end else begin
                reset_n = 1;
                tick();
            end
            check($sformatf("v%0d valid", i), 16'(valid1), 16'(v.ev));
            check($sformatf("v%0d addr", i), addr1, v.eaddr);
            check($sformatf("v%0d busy", i), 16'(busy1), 16'(v.eb));
            if (v.ev || v.rst) begin
                check($sformatf("v%0d pc", i), pc1, v.ev ? v.epc : 16'h0000);
                check($sformatf("v%0d data", i), data1, v.ev ? v.epc + 16'h0100 : 16'h0000);
            end
`ifdef FETCH_PERF_EN
            if (v.pfe >= 0) begin
                check($sformatf("v%0d perf_fetched", i), pfe1, 16'(v.pfe));
                check($sformatf("v%0d perf_flushed", i), pfl1, 16'(v.pfl));
            end
`endif
        end

        // ROM_LATENCY=2: first word after 4th edge, then 1 word/cycle
        fetch_en = 1; instr_ready = 1; redirect_valid = 0;
        reset_n = 0;
        #1;
        check("l2 reset valid", 16'(valid2), 16'h0);
        check("l2 reset addr", addr2, 16'h0000);
        reset_n = 1;
        repeat (3) tick();
        check("l2 latency valid e3", 16'(valid2), 16'h0);
        tick();
        check("l2 first valid", 16'(valid2), 16'h1);
        check("l2 first pc", pc2, 16'h0000);
        check("l2 first data", data2, 16'h0100);
        for (int k = 1; k < 8; k++) begin
            tick();
            check($sformatf("l2 stream valid %0d", k), 16'(valid2), 16'h1);
            check($sformatf("l2 stream pc %0d", k), pc2, 16'(k));
        end
        check("l2 stream addr", addr2, 16'h000A);
        // fetch_en low: in-flight words drain, no new addresses
        fetch_en = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("l2 pause addr %0d", c), addr2, 16'h000A);
            check($sformatf("l2 pause valid %0d", c), 16'(valid2), 16'(c < 2));
            if (c < 2) check($sformatf("l2 pause pc %0d", c), pc2, 16'(8 + c));
        end
        fetch_en = 1;
        tick();
        check("l2 resume addr e1", addr2, 16'h000A);
        tick();
        check("l2 resume addr e2", addr2, 16'h000B);
        tick();
        check("l2 resume valid e3", 16'(valid2), 16'h0);
        tick();
        check("l2 resume pc", pc2, 16'h000A);
        check("l2 resume addr e4", addr2, 16'h000D);
        tick();
        tick();
        check("l2 pre-reset pc", pc2, 16'h000C);
        // mid-stream reset pulse
        reset_n = 0;
        #1;
        check("l2 pulse valid", 16'(valid2), 16'h0);
        check("l2 pulse busy", 16'(busy2), 16'h0);
        check("l2 pulse addr", addr2, 16'h0000);
        check("l2 pulse data", data2, 16'h0000);
        reset_n = 1;
        repeat (3) tick();
        check("l2 restart valid e3", 16'(valid2), 16'h0);
        tick();
        check("l2 restart pc", pc2, 16'h0000);
        check("l2 restart data", data2, 16'h0100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
